// File: rtl/mmss_timer_pkg.sv
// Shared definitions for the minutes:seconds timekeeping core.
package mmss_timer_pkg;

  // Operating state, derived each cycle from adj_switch and the held flags.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_ADJUST  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Count direction (dir input).
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Adjust field select (sel_switch input).
  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

endpackage : mmss_timer_pkg

// File: rtl/mmss_field_counter.sv
// Mod-(MAX+1) field counter. When wrap_en is low, the counter holds at the
// boundary instead of wrapping. carry/borrow flag an inc at MAX or a dec at 0.
module mmss_field_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         wrap_en,
  output logic [W-1:0] value,
  output logic [W-1:0] value_next,
  output logic         carry,
  output logic         borrow
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next value and boundary flags; inc takes priority over dec.
  always_comb begin
    value_d = value_q;
    carry   = 1'b0;
    borrow  = 1'b0;
    if (inc) begin
      carry = (value_q == MAX_V);
      if (value_q == MAX_V) begin
        value_d = wrap_en ? ZERO_V : value_q;
      end else begin
        value_d = value_q + W'(1);
      end
    end else if (dec) begin
      borrow = (value_q == ZERO_V);
      if (value_q == ZERO_V) begin
        value_d = wrap_en ? MAX_V : value_q;
      end else begin
        value_d = value_q - W'(1);
      end
    end else begin
      value_d = value_q;
    end
  end

  // Field register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= ZERO_V;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign value_next = value_d;

endmodule : mmss_field_counter

// File: rtl/mmss_timer_core.sv
// Minutes:seconds timekeeping core: up/down counting with expiry, pause,
// lap display hold and field adjust. All outputs come straight from flops.
module mmss_timer_core
  import mmss_timer_pkg::*;
#(
  parameter int SEC_W   = 6,
  parameter int MIN_W   = 6,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_tick,
  input  logic             adj_tick,
  input  logic             pause,
  input  logic             lap,
  input  logic             sel_switch,
  input  logic             adj_switch,
  input  logic             dir,
  output logic [SEC_W-1:0] outputSeconds,
  output logic [MIN_W-1:0] outputMinutes,
  output logic             running,
  output logic             expired,
  output logic             done,
  output logic             rollover
);

  state_e           state_s;
  logic [SEC_W-1:0] sec_s, sec_next_s;
  logic [MIN_W-1:0] min_s, min_next_s;
  logic             sec_inc_s, sec_dec_s, sec_wrap_s, sec_carry_s, sec_borrow_s;
  logic             min_inc_s, min_dec_s, min_wrap_s, min_carry_s, min_borrow_s;

  logic             paused_q, paused_d, hold_q, hold_d, expired_q, expired_d;
  logic             done_q, done_d, rollover_q, rollover_d, running_q, running_d;
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d, out_sec_q, out_sec_d;
  logic [MIN_W-1:0] lap_min_q, lap_min_d, out_min_q, out_min_d;

  // State by priority: adjust, expired, paused, run.
  always_comb begin
    state_s = ST_RUN;
    if (adj_switch) begin
      state_s = ST_ADJUST;
    end else if (expired_q) begin
      state_s = ST_EXPIRED;
    end else if (paused_q) begin
      state_s = ST_PAUSED;
    end else begin
      state_s = ST_RUN;
    end
  end

  // Seconds control; a tick coinciding with a pause pulse is dropped.
  always_comb begin
    sec_inc_s  = 1'b0;
    sec_dec_s  = 1'b0;
    sec_wrap_s = 1'b1;
    case (state_s)
      ST_RUN: begin
        if (count_tick && !pause) begin
          if (dir == DIR_UP) begin
            sec_inc_s = 1'b1;
          end else begin
            sec_dec_s  = 1'b1;
            // At 00:00 the seconds field must hold rather than wrap.
            sec_wrap_s = (min_s != {MIN_W{1'b0}});
          end
        end else begin
          sec_inc_s = 1'b0;
        end
      end
      ST_ADJUST: begin
        sec_inc_s = adj_tick && (sel_switch == SEL_SEC);
      end
      default: begin
        sec_inc_s = 1'b0;
      end
    endcase
  end

  // Minutes control: chained from seconds when counting, standalone in adjust.
  always_comb begin
    min_inc_s  = 1'b0;
    min_dec_s  = 1'b0;
    min_wrap_s = 1'b1;
    case (state_s)
      ST_RUN: begin
        min_inc_s  = sec_carry_s;
        min_dec_s  = sec_borrow_s;
        // Counting down never wraps minutes; a borrow at 0 means expiry.
        min_wrap_s = (dir == DIR_UP);
      end
      ST_ADJUST: begin
        min_inc_s = adj_tick && (sel_switch == SEL_MIN);
      end
      default: begin
        min_inc_s = 1'b0;
      end
    endcase
  end

  mmss_field_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .inc        (sec_inc_s),
    .dec        (sec_dec_s),
    .wrap_en    (sec_wrap_s),
    .value      (sec_s),
    .value_next (sec_next_s),
    .carry      (sec_carry_s),
    .borrow     (sec_borrow_s)
  );

  mmss_field_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk        (clk),
    .rst        (rst),
    .inc        (min_inc_s),
    .dec        (min_dec_s),
    .wrap_en    (min_wrap_s),
    .value      (min_s),
    .value_next (min_next_s),
    .carry      (min_carry_s),
    .borrow     (min_borrow_s)
  );

  // Flag updates, lap capture and registered output selection.
  always_comb begin
    paused_d  = paused_q;
    hold_d    = hold_q;
    expired_d = expired_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    case (state_s)
      ST_RUN, ST_PAUSED: begin
        paused_d = pause ? ~paused_q : paused_q;
        if (lap) begin
          hold_d = ~hold_q;
          if (!hold_q) begin
            lap_sec_d = sec_s;
            lap_min_d = min_s;
          end else begin
            lap_sec_d = lap_sec_q;
            lap_min_d = lap_min_q;
          end
        end else begin
          hold_d = hold_q;
        end
        // A minutes borrow only occurs on a down tick at 00:00.
        expired_d = min_borrow_s;
      end
      ST_ADJUST: begin
        hold_d    = 1'b0;
        expired_d = 1'b0;
      end
      default: begin
        expired_d = expired_q;
      end
    endcase
    out_sec_d  = hold_d ? lap_sec_d : sec_next_s;
    out_min_d  = hold_d ? lap_min_d : min_next_s;
    running_d  = (state_s == ST_RUN);
    done_d     = min_borrow_s;
    rollover_d = min_carry_s && (state_s == ST_RUN);
  end

  // Flag and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      paused_q   <= 1'b0;
      hold_q     <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
      rollover_q <= 1'b0;
      running_q  <= 1'b0;
      lap_sec_q  <= {SEC_W{1'b0}};
      lap_min_q  <= {MIN_W{1'b0}};
      out_sec_q  <= {SEC_W{1'b0}};
      out_min_q  <= {MIN_W{1'b0}};
    end else begin
      paused_q   <= paused_d;
      hold_q     <= hold_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
      rollover_q <= rollover_d;
      running_q  <= running_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      out_sec_q  <= out_sec_d;
      out_min_q  <= out_min_d;
    end
  end

  assign outputSeconds = out_sec_q;
  assign outputMinutes = out_min_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign done          = done_q;
  assign rollover      = rollover_q;

endmodule : mmss_timer_core

// File: tb/tb_mmss_timer_core.sv
// Directed bench for mmss_timer_core with a cycle-level reference model.
module tb_mmss_timer_core;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int TOTAL   = (SEC_MAX + 1) * (MIN_MAX + 1);

  // Field widths must be able to hold their terminal values.
  if ((2 ** SEC_W) <= SEC_MAX) begin : g_sec_w_bad
    $error("SEC_W too narrow for SEC_MAX");
  end
  if ((2 ** MIN_W) <= MIN_MAX) begin : g_min_w_bad
    $error("MIN_W too narrow for MIN_MAX");
  end

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             count_tick = 1'b0, adj_tick = 1'b0, pause = 1'b0, lap = 1'b0;
  logic             sel_switch = 1'b0, adj_switch = 1'b0, dir = 1'b0;
  logic [SEC_W-1:0] outputSeconds;
  logic [MIN_W-1:0] outputMinutes;
  logic             running, expired, done, rollover;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state (count kept as minutes/seconds plus flags).
  int m_sec = 0, m_min = 0, m_lsec = 0, m_lmin = 0;
  bit m_paused = 1'b0, m_hold = 1'b0, m_exp = 1'b0;
  bit m_done = 1'b0, m_roll = 1'b0, m_run = 1'b0;

  mmss_timer_core #(
    .SEC_W(SEC_W), .MIN_W(MIN_W), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .count_tick    (count_tick),
    .adj_tick      (adj_tick),
    .pause         (pause),
    .lap           (lap),
    .sel_switch    (sel_switch),
    .adj_switch    (adj_switch),
    .dir           (dir),
    .outputSeconds (outputSeconds),
    .outputMinutes (outputMinutes),
    .running       (running),
    .expired       (expired),
    .done          (done),
    .rollover      (rollover)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: treats the count as a single number of seconds.
  always @(posedge clk) begin : model
    int  tot, nsec, nmin, nlsec, nlmin;
    bit  np, nh, ne, nd, nr, nrun, in_adj;
    tot = m_min * (SEC_MAX + 1) + m_sec;
    nsec = m_sec; nmin = m_min; nlsec = m_lsec; nlmin = m_lmin;
    np = m_paused; nh = m_hold; ne = m_exp; nd = 1'b0; nr = 1'b0;
    in_adj = adj_switch;
    nrun = !in_adj && !m_exp && !m_paused;
    if (rst) begin
      nsec = 0; nmin = 0; nlsec = 0; nlmin = 0;
      np = 1'b0; nh = 1'b0; ne = 1'b0; nrun = 1'b0;
    end else if (in_adj) begin
      ne = 1'b0;
      nh = 1'b0;
      if (adj_tick) begin
        if (sel_switch) nsec = (m_sec + 1) % (SEC_MAX + 1);
        else            nmin = (m_min + 1) % (MIN_MAX + 1);
      end
    end else if (!m_exp) begin
      if (nrun && count_tick && !pause) begin
        if (!dir) begin
          if (tot == TOTAL - 1) begin tot = 0; nr = 1'b1; end
          else tot = tot + 1;
        end else begin
          if (tot == 0) begin ne = 1'b1; nd = 1'b1; end
          else tot = tot - 1;
        end
        nsec = tot % (SEC_MAX + 1);
        nmin = tot / (SEC_MAX + 1);
      end
      if (pause) np = !m_paused;
      if (lap) begin
        if (!m_hold) begin nlsec = m_sec; nlmin = m_min; end
        nh = !m_hold;
      end
    end
    m_sec <= nsec; m_min <= nmin; m_lsec <= nlsec; m_lmin <= nlmin;
    m_paused <= np; m_hold <= nh; m_exp <= ne;
    m_done <= nd; m_roll <= nr; m_run <= nrun;
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sec",      int'(outputSeconds), m_hold ? m_lsec : m_sec);
      check("min",      int'(outputMinutes), m_hold ? m_lmin : m_min);
      check("running",  int'(running),  int'(m_run));
      check("expired",  int'(expired),  int'(m_exp));
      check("done",     int'(done),     int'(m_done));
      check("rollover", int'(rollover), int'(m_roll));
    end
  end

  // One cycle of pulses, ending on the following falling edge.
  task automatic cyc(input logic ct, input logic at, input logic pa, input logic la);
    count_tick = ct; adj_tick = at; pause = pa; lap = la;
    @(negedge clk);
    count_tick = 1'b0; adj_tick = 1'b0; pause = 1'b0; lap = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic lit_mmss(input string nm, input int mm, input int ss);
    check({nm, ".min"}, int'(outputMinutes), mm);
    check({nm, ".sec"}, int'(outputSeconds), ss);
  endtask

  initial begin
    // Reset state and first count-up.
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    lit_mmss("reset", 0, 0);
    check("reset.running", int'(running), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("run_after_reset", int'(running), 1);
    repeat (61) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("up61", 1, 1);

    // Preload 59:58 and roll over.
    do_reset();
    adj_switch = 1'b1; sel_switch = 1'b0;
    repeat (59) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    sel_switch = 1'b1;
    repeat (58) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit_mmss("preload", 59, 58);
    adj_switch = 1'b0; dir = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("top", 59, 59);
    check("roll_early", int'(rollover), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("wrap", 0, 0);
    check("roll_pulse", int'(rollover), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("roll_clear", int'(rollover), 0);

    // Countdown to expiry, expired freeze and clear via adjust.
    do_reset();
    adj_switch = 1'b1; sel_switch = 1'b1;
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    adj_switch = 1'b0; dir = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("down1", 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("down0", 0, 0);
    check("not_expired_yet", int'(expired), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("expired_set", int'(expired), 1);
    check("done_pulse", int'(done), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("done_clear", int'(done), 0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    dir = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("frozen", 0, 0);
    check("expired_held", int'(expired), 1);
    adj_switch = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("expired_cleared", int'(expired), 0);
    adj_switch = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("after_expiry", 0, 1);

    // Pause coincident with a tick, ticks while paused, resume.
    do_reset();
    dir = 1'b0;
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    lit_mmss("pause_drop", 0, 10);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("paused", 0, 10);
    check("paused_running", int'(running), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("resumed", 0, 11);

    // Adjust wraps without carry; count_tick and dir ignored in adjust.
    do_reset();
    adj_switch = 1'b1; sel_switch = 1'b1; dir = 1'b1;
    repeat (59) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("adj_sec59", 0, 59);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit_mmss("adj_sec_wrap", 0, 0);
    sel_switch = 1'b0;
    repeat (59) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit_mmss("adj_min59", 59, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit_mmss("adj_min_wrap", 0, 0);
    adj_switch = 1'b0; dir = 1'b0;

    // Lap hold, simultaneous pause+lap, adjust clears hold, reset mid-run.
    do_reset();
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("lap_hold", 0, 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    lit_mmss("lap_release", 0, 9);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("pause_lap", 0, 9);
    adj_switch = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    adj_switch = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("pre_rst", 0, 11);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit_mmss("mid_rst", 0, 0);
    check("mid_rst.running", int'(running), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mmss_timer_core
